// File: rtl/spi_clk_pkg.sv
`default_nettype none
// ============================================================================
//  spi_clk_pkg
//  Shared state encoding and phase-length helper for the SPI SCLK generator.
//  Revision: 1.0
// ============================================================================
package spi_clk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH_A = 2'd1,
        PH_B = 2'd2
    } state_t;

    localparam int DIV_MIN = 2;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } phase_len_t;

    // Phase A takes the odd cycle so the idle-level half is never the shorter one.
    function automatic phase_len_t phase_len(input logic [31:0] n);
        phase_len_t r;
        r.b = n >> 1;
        r.a = n - r.b;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_phase_cnt.sv
`default_nettype none
// ============================================================================
//  spi_phase_cnt
//  Loadable down counter that stops at 1 and flags its terminal count.
//  Revision: 1.0
// ============================================================================
module spi_phase_cnt
    import spi_clk_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;

    // Saturates at 1 (and sits at 0 after reset) so an idle counter never wraps.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (i_load) begin
                r_cnt <= i_load_val;
            end else if (r_cnt > c_one) begin
                r_cnt <= r_cnt - c_one;
            end
        end
    end

    assign o_tc = (r_cnt == c_one);

endmodule
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  spi_sclk_gen
//  Programmable-ratio SPI serial clock with CPOL, bounded bursts and edge strobes.
//  Revision: 1.0
// ============================================================================
module spi_sclk_gen
    import spi_clk_pkg::*;
#(
    parameter int DIV_W = 8,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_cpol,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_nbits,
    output logic             o_sclk,
    output logic             o_lead,
    output logic             o_trail,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [DIV_W-1:0] c_div_min = DIV_W'(DIV_MIN);
    localparam logic [CNT_W:0]   c_one     = (CNT_W+1)'(1);

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_a, r_b;
    logic             r_cpol;
    logic [CNT_W:0]   r_pulses;
    logic             r_sclk, r_lead, r_trail, r_busy, r_done;

    logic [DIV_W-1:0] w_n_in, w_a_in, w_b_in, w_load_val;
    logic [CNT_W:0]   w_nbits_in;
    phase_len_t       w_len;
    logic             w_load, w_tc, w_accept, w_pulse_dec;
    logic             w_sclk_nxt, w_lead_nxt, w_trail_nxt, w_busy_nxt, w_done_nxt;

    assign w_n_in     = (i_div < c_div_min) ? c_div_min : i_div;
    assign w_len      = phase_len(32'(w_n_in));
    assign w_a_in     = DIV_W'(w_len.a);
    assign w_b_in     = DIV_W'(w_len.b);
    assign w_nbits_in = (i_nbits == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, i_nbits};

    spi_phase_cnt #(
        .WIDTH      (DIV_W)
    ) u_phase_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output logic; a disabled cycle holds everything but strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = r_a;
        w_accept    = 1'b0;
        w_pulse_dec = 1'b0;
        w_sclk_nxt  = r_sclk;
        w_lead_nxt  = 1'b0;
        w_trail_nxt = 1'b0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        if (i_en) begin
            case (r_state)
                IDLE: begin
                    w_sclk_nxt = i_cpol;
                    if (i_start) begin
                        w_accept    = 1'b1;
                        w_state_nxt = PH_A;
                        w_load      = 1'b1;
                        w_load_val  = w_a_in;
                        w_busy_nxt  = 1'b1;
                    end
                end
                PH_A: begin
                    if (w_tc) begin
                        w_state_nxt = PH_B;
                        w_load      = 1'b1;
                        w_load_val  = r_b;
                        w_sclk_nxt  = ~r_cpol;
                        w_lead_nxt  = 1'b1;
                    end
                end
                PH_B: begin
                    if (w_tc) begin
                        w_trail_nxt = 1'b1;
                        w_sclk_nxt  = r_cpol;
                        if (r_pulses != c_one) begin
                            w_state_nxt = PH_A;
                            w_load      = 1'b1;
                            w_load_val  = r_a;
                            w_pulse_dec = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sclk   <= 1'b0;
            r_lead   <= 1'b0;
            r_trail  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_cpol   <= 1'b0;
            r_pulses <= '0;
        end else begin
            r_sclk  <= w_sclk_nxt;
            r_lead  <= w_lead_nxt;
            r_trail <= w_trail_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_accept) begin
                r_a      <= w_a_in;
                r_b      <= w_b_in;
                r_cpol   <= i_cpol;
                r_pulses <= w_nbits_in;
            end else if (w_pulse_dec) begin
                r_pulses <= r_pulses - c_one;
            end
        end
    end

    assign o_sclk  = r_sclk;
    assign o_lead  = r_lead;
    assign o_trail = r_trail;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  tb_spi_sclk_gen
//  Scoreboard bench: per-cycle expected {sclk,lead,trail,busy,done} vectors.
//  Revision: 1.0
// ============================================================================
module tb_spi_sclk_gen;

    logic       clk = 1'b0;
    logic       rst, en, start, cpol;
    logic [7:0] div;
    logic [5:0] nbits;
    logic       sclk, lead, trail, busy, done;

    logic [4:0] sb[$];
    string      tag;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc_cnt  = 0;

    spi_sclk_gen #(
        .DIV_W   (8),
        .CNT_W   (6)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_div   (div),
        .i_cpol  (cpol),
        .i_start (start),
        .i_nbits (nbits),
        .o_sclk  (sclk),
        .o_lead  (lead),
        .o_trail (trail),
        .o_busy  (busy),
        .o_done  (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string t, input logic [4:0] obs, input logic [4:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%b exp=%b (sclk,lead,trail,busy,done)",
                     t, cyc_cnt, obs, exp_v);
        end
    endtask

    // Expected outputs t cycles after the accept edge of a burst.
    function automatic logic [4:0] exp_at(input int n, input logic cp, input int nb, input int t);
        int a;
        int pos;
        a = n - n / 2;
        if (t > nb * n) return {cp, 1'b0, 1'b1, 1'b0, 1'b1};
        pos = (t - 1) % n;
        return {((pos < a) ? cp : ~cp), (pos == a), (pos == 0 && t > 1), 1'b1, 1'b0};
    endfunction

    function automatic int eff_n(input int dv);
        return (dv < 2) ? 2 : dv;
    endfunction

    function automatic int eff_nb(input int nb);
        return (nb == 0) ? 64 : nb;
    endfunction

    task automatic push_burst(input int dv, input logic cp, input int nb);
        int n;
        int k;
        n = eff_n(dv);
        k = eff_nb(nb);
        for (int t = 1; t <= k * n + 1; t++) sb.push_back(exp_at(n, cp, k, t));
    endtask

    task automatic tick();
        logic [4:0] exp_v;
        @(posedge clk);
        #1;
        cyc_cnt++;
        exp_v = 5'bxxxxx;
        if (sb.size() != 0) exp_v = sb.pop_front();
        check_eq(tag, {sclk, lead, trail, busy, done}, exp_v);
    endtask

    task automatic idle(input logic cp);
        cpol  = cp;
        start = 1'b0;
        sb.push_back({cp, 4'b0000});
        tick();
    endtask

    task automatic burst(input string t, input int dv, input logic cp, input int nb);
        int total;
        tag   = t;
        div   = 8'(dv);
        cpol  = cp;
        nbits = 6'(nb);
        start = 1'b1;
        total = eff_nb(nb) * eff_n(dv) + 1;
        push_burst(dv, cp, nb);
        tick();
        start = 1'b0;
        repeat (total - 1) tick();
        idle(cp);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; cpol = 1'b1; div = 8'd4; nbits = 6'd1;

        tag = "reset";
        sb.push_back(5'b00000);
        sb.push_back(5'b00000);
        tick();
        tick();
        rst = 1'b0;
        tag = "idle_cpol";
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        burst("even_div4", 4, 1'b0, 2);
        burst("odd_div5_cpol1", 5, 1'b1, 1);
        burst("clamp_div1", 1, 1'b0, 1);
        burst("clamp_div0_max", 0, 1'b0, 0);

        // Start held high; busy-time input changes only take effect at the next accept.
        tag = "b2b"; div = 8'd3; cpol = 1'b0; nbits = 6'd2; start = 1'b1;
        push_burst(3, 1'b0, 2);
        push_burst(6, 1'b1, 1);
        tick();
        div = 8'd6; cpol = 1'b1; nbits = 6'd1;
        repeat (7) tick();
        start = 1'b0;
        repeat (6) tick();
        idle(1'b1);
        idle(1'b0);

        tag = "pause_div4"; div = 8'd4; cpol = 1'b0; nbits = 6'd1; start = 1'b1;
        sb.push_back(5'b00010);
        tick();
        start = 1'b0;
        sb.push_back(5'b00010);
        tick();
        en = 1'b0;
        repeat (3) sb.push_back(5'b00010);
        repeat (3) tick();
        en = 1'b1;
        sb.push_back(5'b11010);
        sb.push_back(5'b10010);
        sb.push_back(5'b00101);
        repeat (3) tick();
        idle(1'b0);

        tag = "pause_on_lead"; div = 8'd2; cpol = 1'b0; nbits = 6'd1; start = 1'b1;
        sb.push_back(5'b00010);
        tick();
        start = 1'b0;
        sb.push_back(5'b11010);
        tick();
        en = 1'b0;
        sb.push_back(5'b10010);
        tick();
        en = 1'b1;
        sb.push_back(5'b00101);
        tick();
        idle(1'b0);

        tag = "rst_mid"; div = 8'd4; cpol = 1'b1; nbits = 6'd4; start = 1'b1;
        for (int t = 1; t <= 3; t++) sb.push_back(exp_at(4, 1'b1, 4, t));
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        sb.push_back(5'b00000);
        tick();
        rst = 1'b0;
        idle(1'b0);

        // Fresh burst after the abort, with a stray start while busy that must not queue.
        tag = "after_rst"; div = 8'd4; cpol = 1'b0; nbits = 6'd2; start = 1'b1;
        push_burst(4, 1'b0, 2);
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        tag = "no_queued_start";
        idle(1'b0);
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
